// File: rtl/day_step_sequencer.sv
// rtl/day_step_sequencer.sv - day-of-year stepper with slow/fast rate FSM and debounced fast key
module day_step_sequencer #(
  parameter int SLOW_DIV = 250,
  parameter int FAST_DIV = 50,
  parameter int DEB_CYC  = 4
) (
  input  logic       ADC_CLK_10,
  input  logic       KEY0,
  input  logic       key1_n,
  input  logic       run,
  input  logic       leap,
  output logic [8:0] day_of_year,
  output logic       step_pulse,
  output logic       wrap,
  output logic       fast_mode,
  output logic [1:0] state
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int PW      = $clog2(MAX_DIV);
  localparam int DW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  localparam logic [PW-1:0] SLOW_TOP = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] FAST_TOP = PW'(FAST_DIV - 1);
  localparam logic [DW-1:0] DEB_TOP  = DW'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_t;

  state_t        st;
  state_t        st_nxt;
  logic          sync1;
  logic          sync2;
  logic          key_held;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] presc;
  logic [PW-1:0] top;
  logic [8:0]    last_day;

  assign key_held = ~sync2;
  assign top      = (st == FAST) ? FAST_TOP : SLOW_TOP;
  assign last_day = leap ? 9'd366 : 9'd365;
  assign state    = st;

  // fast_mode only follows the key after DEB_CYC agreeing samples in a row
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      deb_cnt   <= '0;
      fast_mode <= 1'b0;
    end else begin
      sync1 <= key1_n;
      sync2 <= sync1;
      if (key_held != fast_mode) begin
        if (deb_cnt == DEB_TOP) begin
          fast_mode <= key_held;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (run) st_nxt = fast_mode ? FAST : SLOW;
      end
      SLOW: begin
        if (!run)          st_nxt = IDLE;
        else if (fast_mode) st_nxt = FAST;
      end
      FAST: begin
        if (!run)           st_nxt = IDLE;
        else if (!fast_mode) st_nxt = SLOW;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // A state change restarts the prescaler and suppresses any step due this cycle
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      st          <= IDLE;
      presc       <= '0;
      day_of_year <= 9'd1;
      step_pulse  <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      st         <= st_nxt;
      step_pulse <= 1'b0;
      wrap       <= 1'b0;
      if ((st_nxt != st) || (st == IDLE)) begin
        presc <= '0;
      end else if (presc == top) begin
        presc      <= '0;
        step_pulse <= 1'b1;
        if (day_of_year >= last_day) begin
          day_of_year <= 9'd1;
          wrap        <= 1'b1;
        end else begin
          day_of_year <= day_of_year + 9'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_day_step_sequencer.sv
// tb/tb_day_step_sequencer.sv - scoreboard bench for day_step_sequencer
module tb_day_step_sequencer;

  logic       clk;
  logic       rst_n;
  logic       key1_n;
  logic       run;
  logic       leap;
  logic [8:0] day_of_year;
  logic       step_pulse;
  logic       wrap;
  logic       fast_mode;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cyc;
    int day;
    int wr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  day_step_sequencer #(
    .SLOW_DIV(4),
    .FAST_DIV(2),
    .DEB_CYC (3)
  ) dut (
    .ADC_CLK_10 (clk),
    .KEY0       (rst_n),
    .key1_n     (key1_n),
    .run        (run),
    .leap       (leap),
    .day_of_year(day_of_year),
    .step_pulse (step_pulse),
    .wrap       (wrap),
    .fast_mode  (fast_mode),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int d, input int w);
    exp_t e;
    e.cyc = c;
    e.day = d;
    e.wr  = w;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every step_pulse must match the next scheduled step
  always @(negedge clk) begin
    chk("day_in_range", int'(day_of_year >= 9'd1 && day_of_year <= 9'd366), 1);
    if (step_pulse) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step at cyc %0d: actual day=%0d required=no step", cyc, day_of_year);
      end else begin
        mon_e = q.pop_front();
        chk("step_cycle", cyc, mon_e.cyc);
        chk("step_day", day_of_year, mon_e.day);
        chk("step_wrap", wrap, mon_e.wr);
      end
    end else begin
      chk("wrap_without_step", wrap, 0);
    end
  end

  initial begin
    int s, y2, y3, t4, t5, s5, s6;
    rst_n  = 1'b0;
    key1_n = 1'b1;
    run    = 1'b0;
    leap   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_day", day_of_year, 1);
    chk("rst_state", state, 0);
    chk("rst_fast", fast_mode, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_wrap", wrap, 0);

    // years 1..3: plain, leap, leap dropped at 366
    rst_n = 1'b1;
    run   = 1'b1;
    s  = cyc + 1;
    y2 = s + 4 * 365;
    y3 = y2 + 4 * 366;
    t4 = y3 + 4 * 366;
    for (int k = 1; k <= 365; k++) push(s + 4 * k, (k == 365) ? 1 : k + 1, (k == 365) ? 1 : 0);
    for (int j = 1; j <= 366; j++) push(y2 + 4 * j, (j == 366) ? 1 : j + 1, (j == 366) ? 1 : 0);
    for (int j = 1; j <= 366; j++) push(y3 + 4 * j, (j == 366) ? 1 : j + 1, (j == 366) ? 1 : 0);

    wait_cyc(s);
    chk("slow_entry_state", state, 1);
    chk("slow_entry_day", day_of_year, 1);
    wait_cyc(s + 5);
    chk("pulse_one_cycle", step_pulse, 0);
    chk("day_after_first", day_of_year, 2);
    wait_cyc(y2);
    chk("year1_wrapped", day_of_year, 1);
    leap = 1'b1;
    wait_cyc(y3 + 4 * 365 + 1);
    chk("leap_day_366", day_of_year, 366);
    leap = 1'b0;
    wait_cyc(y3 + 4 * 365 + 3);
    chk("hold_366_after_leap_drop", day_of_year, 366);

    // glitch, then held press, then release
    wait_cyc(t4);
    push(t4 + 4, 2, 0);
    push(t4 + 8, 3, 0);
    push(t4 + 12, 4, 0);
    push(t4 + 16, 5, 0);
    push(t4 + 18, 6, 0);
    push(t4 + 20, 7, 0);
    push(t4 + 22, 8, 0);
    push(t4 + 24, 9, 0);
    push(t4 + 30, 10, 0);
    push(t4 + 34, 11, 0);
    key1_n = 1'b0;
    wait_cyc(t4 + 2);
    key1_n = 1'b1;
    for (int c = t4 + 3; c <= t4 + 8; c++) begin
      wait_cyc(c);
      chk("glitch_ignored", fast_mode, 0);
    end
    key1_n = 1'b0;
    wait_cyc(t4 + 12);
    chk("fast_not_yet", fast_mode, 0);
    wait_cyc(t4 + 13);
    chk("fast_after_5", fast_mode, 1);
    chk("still_slow", state, 1);
    wait_cyc(t4 + 14);
    chk("state_fast", state, 2);
    wait_cyc(t4 + 20);
    key1_n = 1'b1;
    wait_cyc(t4 + 24);
    chk("fast_held", fast_mode, 1);
    wait_cyc(t4 + 25);
    chk("fast_released", fast_mode, 0);
    chk("still_fast", state, 2);
    wait_cyc(t4 + 26);
    chk("back_to_slow", state, 1);
    chk("no_step_on_change", step_pulse, 0);

    // pause with run=0 at prescaler 2
    t5 = t4 + 34;
    s5 = t5 + 9;
    for (int k = 1; k <= 46; k++) push(s5 + 4 * k, 11 + k, 0);
    wait_cyc(t5 + 2);
    run = 1'b0;
    wait_cyc(t5 + 3);
    chk("paused_idle", state, 0);
    wait_cyc(t5 + 8);
    chk("paused_day_frozen", day_of_year, 11);
    chk("paused_still_idle", state, 0);
    run = 1'b1;
    wait_cyc(s5);
    chk("resume_slow", state, 1);

    // asynchronous reset mid-count at day 57
    wait_cyc(s5 + 184);
    chk("day_57", day_of_year, 57);
    wait_cyc(s5 + 186);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_day", day_of_year, 1);
    chk("async_rst_state", state, 0);
    chk("async_rst_fast", fast_mode, 0);
    chk("async_rst_step", step_pulse, 0);
    #1;
    rst_n = 1'b1;
    s6 = s5 + 187;
    push(s6 + 4, 2, 0);
    push(s6 + 8, 3, 0);
    wait_cyc(s6);
    chk("post_rst_slow", state, 1);
    chk("post_rst_day", day_of_year, 1);
    wait_cyc(s6 + 8);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("all_steps_seen", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
